// File: rtl/dpram_pkg.sv
// Shared definitions for the dpram copy engine.
//   AW_DEF / DW_DEF : default address and data widths
//   state_e         : copy engine state encoding
package dpram_pkg;

    localparam int AW_DEF = 10;
    localparam int DW_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/dpram_copy_engine_copy_dir_chk.sv
// Copy direction check for the memmove engine (purely combinational).
//   src_addr, dst_addr : first source / destination word
//   len                : word count, 0..2^AW
//   backward           : 1 when the destination overlaps the source from above
//   first_src/first_dst: first addresses the engine must touch
module copy_dir_chk
    import dpram_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW:0]   len,
    output logic          backward,
    output logic [AW-1:0] first_src,
    output logic [AW-1:0] first_dst
);

    localparam logic [AW-1:0] ONE_A = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0] diff;
    logic [AW-1:0] len_m1;

    // A destination that starts inside the source region (above it) would
    // overwrite source words before they are read, so copy from the top down.
    // len = 2^AW truncates to 0 here; len_m1 then wraps to 2^AW-1 as required.
    assign diff      = dst_addr - src_addr;
    assign len_m1    = len[AW-1:0] - ONE_A;
    assign backward  = (diff != '0) && ({1'b0, diff} < len);
    assign first_src = backward ? (src_addr + len_m1) : src_addr;
    assign first_dst = backward ? (dst_addr + len_m1) : dst_addr;

endmodule

// File: rtl/dpram_copy_engine.sv
// Block-copy (memmove) engine driving one port of a registered-read dpram.
//   clk, rst_n            : clock, async active-low reset
//   start, src_addr,
//   dst_addr, len         : copy request (sampled in IDLE only)
//   busy, done            : in-progress flag, one-cycle completion pulse
//   mem_en, mem_addr,
//   mem_data              : dpram write enable / address / write data
//   mem_out               : dpram read data, valid one cycle after address
//
// state   | meaning
// IDLE    | waiting for start
// RD      | present cur_src to the memory
// WR      | write the word just read to cur_dst, step pointers
// DONE    | one-cycle done pulse
module dpram_copy_engine
    import dpram_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    input  logic [DW-1:0] mem_out
);

    localparam logic [AW-1:0] ONE_A = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   ONE_L = {{AW{1'b0}}, 1'b1};

    state_e        state_q, state_d;
    logic [AW-1:0] cur_src_q, cur_src_d;
    logic [AW-1:0] cur_dst_q, cur_dst_d;
    logic [AW:0]   remaining_q, remaining_d;
    logic          bwd_q, bwd_d;

    logic          chk_backward;
    logic [AW-1:0] chk_first_src;
    logic [AW-1:0] chk_first_dst;

    copy_dir_chk #(.AW(AW)) u_dir_chk (
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .backward  (chk_backward),
        .first_src (chk_first_src),
        .first_dst (chk_first_dst)
    );

    always_comb begin
        state_d     = state_q;
        cur_src_d   = cur_src_q;
        cur_dst_d   = cur_dst_q;
        remaining_d = remaining_q;
        bwd_d       = bwd_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        cur_src_d   = chk_first_src;
                        cur_dst_d   = chk_first_dst;
                        remaining_d = len;
                        bwd_d       = chk_backward;
                        state_d     = ST_RD;
                    end
                end
            end
            ST_RD: begin
                state_d = ST_WR;
            end
            ST_WR: begin
                cur_src_d   = bwd_q ? (cur_src_q - ONE_A) : (cur_src_q + ONE_A);
                cur_dst_d   = bwd_q ? (cur_dst_q - ONE_A) : (cur_dst_q + ONE_A);
                remaining_d = remaining_q - ONE_L;
                state_d     = (remaining_q == ONE_L) ? ST_DONE : ST_RD;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cur_src_q   <= '0;
            cur_dst_q   <= '0;
            remaining_q <= '0;
            bwd_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_src_q   <= cur_src_d;
            cur_dst_q   <= cur_dst_d;
            remaining_q <= remaining_d;
            bwd_q       <= bwd_d;
        end
    end

    // Outputs decode straight from state_q, so reset drops mem_en immediately.
    always_comb begin
        busy     = (state_q == ST_RD) || (state_q == ST_WR);
        done     = (state_q == ST_DONE);
        mem_en   = (state_q == ST_WR);
        mem_addr = '0;
        if (state_q == ST_RD) mem_addr = cur_src_q;
        if (state_q == ST_WR) mem_addr = cur_dst_q;
        // mem_out is the dpram output register holding the word read in RD.
        mem_data = (state_q == ST_WR) ? mem_out : '0;
    end

endmodule

// File: tb/tb_dpram_copy_engine.sv
module tb_dpram_copy_engine;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [9:0]  src_addr;
    logic [9:0]  dst_addr;
    logic [10:0] len;
    logic        busy;
    logic        done;
    logic        mem_en;
    logic [9:0]  mem_addr;
    logic [15:0] mem_data;
    logic [15:0] mem_out;

    logic [15:0] mem [0:1023];
    logic        tb_we;
    logic [9:0]  tb_addr;
    logic [15:0] tb_wdata;

    int checks = 0;
    int errors = 0;

    dpram_copy_engine #(.AW(10), .DW(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .mem_en   (mem_en),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_out  (mem_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read single port memory; tb_we is the bench preload path.
    always @(posedge clk) begin
        if (tb_we) mem[tb_addr] <= tb_wdata;
        else if (mem_en) mem[mem_addr] <= mem_data;
        mem_out <= mem[mem_addr];
    end

    task automatic poke(input logic [9:0] a, input logic [15:0] v);
        @(negedge clk);
        tb_we = 1'b1; tb_addr = a; tb_wdata = v;
        @(posedge clk);
        #1 tb_we = 1'b0;
    endtask

    // Runs one copy; cycle 0 is the start edge. Optionally pulses a second
    // start (src 0, dst 50, len 2) in cycle inj.
    task automatic run_copy(input logic [9:0] s, input logic [9:0] d,
                            input logic [10:0] l, input int inj,
                            output int done_cyc, output int wr_cnt,
                            output int first_wr, output int done_cnt);
        int lim;
        lim = 2 * int'(l) + 8;
        done_cyc = -1; wr_cnt = 0; first_wr = -1; done_cnt = 0;
        @(negedge clk);
        start = 1'b1; src_addr = s; dst_addr = d; len = l;
        @(posedge clk);
        #1 start = 1'b0;
        src_addr = 10'h3A5; dst_addr = 10'h15A; len = 11'd7;
        for (int c = 1; c <= lim; c++) begin
            @(negedge clk);
            if (mem_en === 1'b1) begin
                if (first_wr < 0) first_wr = int'(mem_addr);
                wr_cnt++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (c == inj) begin
                start = 1'b1; src_addr = 10'd0; dst_addr = 10'd50; len = 11'd2;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        checks++;
        if ({busy, done, mem_en, mem_addr, mem_data} !== 29'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b en=%b addr=%0d data=%h, want all 0",
                     busy, done, mem_en, mem_addr, mem_data);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_forward;
        int dc, wc, fw, dn;
        for (int i = 0; i < 4; i++) poke(10'(i), 16'(i + 1));
        run_copy(10'd0, 10'd100, 11'd4, -1, dc, wc, fw, dn);
        checks++;
        if (dc != 9) begin errors++; $display("FAIL fwd_done_cycle: got %0d want 9", dc); end
        checks++;
        if (wc != 4) begin errors++; $display("FAIL fwd_writes: got %0d want 4", wc); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[100 + i] !== 16'(i + 1)) begin
                errors++; $display("FAIL fwd_dst[%0d]: got %h want %h", 100 + i, mem[100 + i], i + 1);
            end
            checks++;
            if (mem[i] !== 16'(i + 1)) begin
                errors++; $display("FAIL fwd_src[%0d]: got %h want %h", i, mem[i], i + 1);
            end
        end
    endtask

    task automatic test_overlap_up;
        int dc, wc, fw, dn;
        for (int i = 0; i < 5; i++) poke(10'(10 + i), 16'hA + 16'(i));
        run_copy(10'd10, 10'd12, 11'd5, -1, dc, wc, fw, dn);
        checks++;
        if (fw != 16) begin errors++; $display("FAIL up_first_write: got %0d want 16", fw); end
        checks++;
        if (dc != 11) begin errors++; $display("FAIL up_done_cycle: got %0d want 11", dc); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (mem[12 + i] !== 16'hA + 16'(i)) begin
                errors++; $display("FAIL up_dst[%0d]: got %h want %h", 12 + i, mem[12 + i], 10 + i);
            end
        end
    endtask

    task automatic test_overlap_down;
        int dc, wc, fw, dn;
        for (int i = 0; i < 5; i++) poke(10'(20 + i), 16'hA + 16'(i));
        run_copy(10'd20, 10'd18, 11'd5, -1, dc, wc, fw, dn);
        checks++;
        if (fw != 18) begin errors++; $display("FAIL down_first_write: got %0d want 18", fw); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (mem[18 + i] !== 16'hA + 16'(i)) begin
                errors++; $display("FAIL down_dst[%0d]: got %h want %h", 18 + i, mem[18 + i], 10 + i);
            end
        end
    endtask

    task automatic test_wrap;
        int dc, wc, fw, dn;
        poke(10'd1022, 16'd7); poke(10'd1023, 16'd8); poke(10'd0, 16'd9);
        run_copy(10'd1022, 10'd500, 11'd3, -1, dc, wc, fw, dn);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem[500 + i] !== 16'(7 + i)) begin
                errors++; $display("FAIL wrap_a[%0d]: got %h want %h", 500 + i, mem[500 + i], 7 + i);
            end
        end
        run_copy(10'd500, 10'd1023, 11'd2, -1, dc, wc, fw, dn);
        checks++;
        if (mem[1023] !== 16'd7) begin errors++; $display("FAIL wrap_b[1023]: got %h want 7", mem[1023]); end
        checks++;
        if (mem[0] !== 16'd8) begin errors++; $display("FAIL wrap_b[0]: got %h want 8", mem[0]); end
    endtask

    task automatic test_same_addr;
        int dc, wc, fw, dn;
        poke(10'd60, 16'h1111); poke(10'd61, 16'h2222);
        run_copy(10'd60, 10'd60, 11'd2, -1, dc, wc, fw, dn);
        checks++;
        if (wc != 2 || fw != 60) begin
            errors++; $display("FAIL same_writes: got %0d writes first %0d want 2 first 60", wc, fw);
        end
        checks++;
        if (mem[60] !== 16'h1111 || mem[61] !== 16'h2222) begin
            errors++; $display("FAIL same_data: got %h %h want 1111 2222", mem[60], mem[61]);
        end
    endtask

    task automatic test_len_zero;
        int dc, wc, fw, dn;
        run_copy(10'd5, 10'd6, 11'd0, -1, dc, wc, fw, dn);
        checks++;
        if (dc != 1 || dn != 1) begin
            errors++; $display("FAIL len0_done: got cycle %0d count %0d want cycle 1 count 1", dc, dn);
        end
        checks++;
        if (wc != 0) begin errors++; $display("FAIL len0_writes: got %0d want 0", wc); end
    endtask

    task automatic test_start_while_busy;
        int dc, wc, fw, dn;
        for (int i = 0; i < 3; i++) poke(10'(30 + i), 16'h3000 + 16'(i));
        poke(10'd50, 16'hBEEF); poke(10'd51, 16'hCAFE);
        run_copy(10'd30, 10'd40, 11'd3, 3, dc, wc, fw, dn);
        checks++;
        if (dc != 7 || dn != 1) begin
            errors++; $display("FAIL busy_done: got cycle %0d count %0d want cycle 7 count 1", dc, dn);
        end
        checks++;
        if (wc != 3) begin errors++; $display("FAIL busy_writes: got %0d want 3", wc); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem[40 + i] !== 16'h3000 + 16'(i)) begin
                errors++; $display("FAIL busy_dst[%0d]: got %h want %h", 40 + i, mem[40 + i], 16'h3000 + i);
            end
        end
        checks++;
        if (mem[50] !== 16'hBEEF || mem[51] !== 16'hCAFE) begin
            errors++; $display("FAIL busy_ignored: got %h %h want beef cafe", mem[50], mem[51]);
        end
    endtask

    task automatic test_reset_mid_copy;
        int wc, dc, fw, dn;
        bit hit;
        for (int i = 0; i < 8; i++) begin
            poke(10'(200 + i), 16'h2000 + 16'(i));
            poke(10'(300 + i), 16'hD000 + 16'(i));
        end
        wc = 0; hit = 1'b0;
        @(negedge clk);
        start = 1'b1; src_addr = 10'd200; dst_addr = 10'd300; len = 11'd8;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 30 && !hit; c++) begin
            @(negedge clk);
            if (mem_en === 1'b1) begin
                if (wc == 3) begin
                    // Assert reset in the middle of the 4th write cycle.
                    rst_n = 1'b0;
                    hit = 1'b1;
                    #1;
                end else begin
                    wc++;
                end
            end
        end
        checks++;
        if (!hit) begin
            errors++; $display("FAIL rst_mid_reach: got %0d writes, want 4th write cycle reached", wc);
        end
        checks++;
        if (mem_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || mem_addr !== 10'd0) begin
            errors++; $display("FAIL rst_mid_outputs: got en=%b busy=%b done=%b addr=%0d want 0",
                               mem_en, busy, done, mem_addr);
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mem[300 + i] !== ((i < 3) ? 16'h2000 + 16'(i) : 16'hD000 + 16'(i))) begin
                errors++; $display("FAIL rst_mid_dst[%0d]: got %h want %h", 300 + i, mem[300 + i],
                                   (i < 3) ? 16'h2000 + i : 16'hD000 + i);
            end
        end
        rst_n = 1'b1;
        run_copy(10'd200, 10'd400, 11'd2, -1, dc, wc, fw, dn);
        checks++;
        if (dc != 5 || mem[400] !== 16'h2000 || mem[401] !== 16'h2001) begin
            errors++; $display("FAIL rst_after_copy: got cycle %0d data %h %h want 5 2000 2001",
                               dc, mem[400], mem[401]);
        end
    endtask

    initial begin
        start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        tb_we = 1'b0; tb_addr = '0; tb_wdata = '0;
        test_reset();
        test_forward();
        test_overlap_up();
        test_overlap_down();
        test_wrap();
        test_same_addr();
        test_len_zero();
        test_start_while_busy();
        test_reset_mid_copy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
